mine_locator: RTL and testbench

Pixel-to-grid hit tester for the VGA mine field: the inverse of the grid-to-pixel mine placement. It accepts a pixel coordinate (from the cursor/player logic) over a valid/ready handshake and scans the mine grid iteratively, one row or column per clock, using add-only stepping. It returns the (row, col) of the mine cell containing the pixel, or a miss. It sits between the input/cursor logic and the game-state logic, which consumes the response.

---
 rtl/mine_locator.sv | 194 +++++++++++++++++++
 tb/tb_mine_locator.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mine_locator.sv
// Pixel-to-grid hit tester: scans the 3x4 mine grid one row/column per clock and reports the containing cell.
// Optional per-cell liveness masking is enabled by defining MINE_LOCATOR_MASK_EN.
module mine_locator #(
  parameter int MINE_W = 32,
  parameter int MINE_H = 64
) (
  input  logic        clk,
  input  logic        rst_n,
`ifdef MINE_LOCATOR_MASK_EN
  input  logic [11:0] alive_mask,
`endif
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [10:0] req_x,
  input  logic [10:0] req_y,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic        resp_hit,
  output logic [1:0]  resp_row,
  output logic [1:0]  resp_col
);

  localparam logic [11:0] X_BASE = 12'h070;
  localparam logic [11:0] X_STEP = 12'h030;
  localparam logic [11:0] Y_BASE = 12'h080;
  localparam logic [11:0] Y_STEP = 12'h060;
  localparam logic [11:0] W_EXT  = 12'(MINE_W);
  localparam logic [11:0] H_EXT  = 12'(MINE_H);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ROW,
    ST_COL,
    ST_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [10:0] x_q, x_d;
  logic [10:0] y_q, y_d;
  logic [1:0]  row_q, row_d;
  logic [1:0]  col_q, col_d;
  logic [11:0] xo_q, xo_d;
  logic [11:0] yo_q, yo_d;
  logic        req_ready_q, req_ready_d;
  logic        resp_valid_q, resp_valid_d;
  logic        resp_hit_q, resp_hit_d;
  logic [1:0]  resp_row_q, resp_row_d;
  logic [1:0]  resp_col_q, resp_col_d;
  logic        x_inside;
  logic        y_inside;
  logic        cell_live;

`ifdef MINE_LOCATOR_MASK_EN
  logic [11:0] mask_q, mask_d;

  assign cell_live = mask_q[{row_q, col_q}];
`else
  assign cell_live = 1'b1;
`endif

  // Bounds are 12 bits wide so origin + size never wraps for any legal sprite size.
  always_comb begin
    x_inside = ({1'b0, x_q} >= xo_q) && ({1'b0, x_q} < (xo_q + W_EXT));
    y_inside = ({1'b0, y_q} >= yo_q) && ({1'b0, y_q} < (yo_q + H_EXT));
  end

  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    y_d          = y_q;
    row_d        = row_q;
    col_d        = col_q;
    xo_d         = xo_q;
    yo_d         = yo_q;
    req_ready_d  = req_ready_q;
    resp_valid_d = resp_valid_q;
    resp_hit_d   = resp_hit_q;
    resp_row_d   = resp_row_q;
    resp_col_d   = resp_col_q;
`ifdef MINE_LOCATOR_MASK_EN
    mask_d       = mask_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (req_valid && req_ready_q) begin
          x_d         = req_x;
          y_d         = req_y;
          row_d       = 2'd0;
          xo_d        = X_BASE;
          req_ready_d = 1'b0;
          state_d     = ST_ROW;
`ifdef MINE_LOCATOR_MASK_EN
          mask_d      = alive_mask;
`endif
        end
      end

      ST_ROW: begin
        if (x_inside) begin
          col_d   = 2'd0;
          yo_d    = Y_BASE;
          state_d = ST_COL;
        end else if (row_q == 2'd2) begin
          resp_valid_d = 1'b1;
          resp_hit_d   = 1'b0;
          resp_row_d   = 2'd0;
          resp_col_d   = 2'd0;
          state_d      = ST_DONE;
        end else begin
          row_d = row_q + 2'd1;
          xo_d  = xo_q + X_STEP;
        end
      end

      // The first matching column wins, so overlapping sprites resolve to the lowest index.
      ST_COL: begin
        if (y_inside) begin
          resp_valid_d = 1'b1;
          resp_hit_d   = cell_live;
          resp_row_d   = row_q;
          resp_col_d   = col_q;
          state_d      = ST_DONE;
        end else if (col_q == 2'd3) begin
          resp_valid_d = 1'b1;
          resp_hit_d   = 1'b0;
          resp_row_d   = 2'd0;
          resp_col_d   = 2'd0;
          state_d      = ST_DONE;
        end else begin
          col_d = col_q + 2'd1;
          yo_d  = yo_q + Y_STEP;
        end
      end

      ST_DONE: begin
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          req_ready_d  = 1'b1;
          state_d      = ST_IDLE;
        end
      end

      default: begin
        resp_valid_d = 1'b0;
        req_ready_d  = 1'b1;
        state_d      = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      x_q          <= '0;
      y_q          <= '0;
      row_q        <= '0;
      col_q        <= '0;
      xo_q         <= '0;
      yo_q         <= '0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_hit_q   <= 1'b0;
      resp_row_q   <= '0;
      resp_col_q   <= '0;
`ifdef MINE_LOCATOR_MASK_EN
      mask_q       <= '0;
`endif
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      row_q        <= row_d;
      col_q        <= col_d;
      xo_q         <= xo_d;
      yo_q         <= yo_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_hit_q   <= resp_hit_d;
      resp_row_q   <= resp_row_d;
      resp_col_q   <= resp_col_d;
`ifdef MINE_LOCATOR_MASK_EN
      mask_q       <= mask_d;
`endif
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_hit   = resp_hit_q;
  assign resp_row   = resp_row_q;
  assign resp_col   = resp_col_q;

endmodule

// File: tb/tb_mine_locator.sv
// Scoreboard bench for mine_locator: directed requests push expected responses, a monitor pops and compares.
// Mask tests run only when MINE_LOCATOR_MASK_EN is defined.
module tb_mine_locator;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [10:0] req_x = '0;
  logic [10:0] req_y = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic        resp_hit;
  logic [1:0]  resp_row;
  logic [1:0]  resp_col;
`ifdef MINE_LOCATOR_MASK_EN
  logic [11:0] alive_mask = 12'hFFF;
`endif

  always #5 clk = ~clk;

  mine_locator #(.MINE_W(32), .MINE_H(64)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
`ifdef MINE_LOCATOR_MASK_EN
    .alive_mask (alive_mask),
`endif
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_x      (req_x),
    .req_y      (req_y),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_hit   (resp_hit),
    .resp_row   (resp_row),
    .resp_col   (resp_col)
  );

  typedef struct {
    logic       hit;
    logic [1:0] row;
    logic [1:0] col;
    int         lat;
    int         acc;
  } exp_t;

  exp_t sb[$];
  int   cycle = 0;
  int   n_vec = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  // Monitor samples just after each rising edge; inputs are driven on falling edges.
  logic       prev_valid = 1'b0;
  logic       prev_hs = 1'b0;
  logic       hold_hit;
  logic [1:0] hold_row;
  logic [1:0] hold_col;

  always begin
    @(posedge clk);
    #1;
    if (!rst_n) begin
      prev_valid = 1'b0;
      prev_hs    = 1'b0;
    end else begin
      if (prev_hs) begin
        checkOutput("req_ready_after_hs", 32'(req_ready), 32'd1);
        checkOutput("resp_valid_after_hs", 32'(resp_valid), 32'd0);
      end
      if (resp_valid && !prev_valid) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("[TB] FAIL unexpected_resp: got hit=%0d row=%0d col=%0d expected no response",
                   resp_hit, resp_row, resp_col);
        end else begin
          exp_t e;
          e = sb.pop_front();
          checkOutput("resp_hit", 32'(resp_hit), 32'(e.hit));
          checkOutput("resp_row", 32'(resp_row), 32'(e.row));
          checkOutput("resp_col", 32'(resp_col), 32'(e.col));
          checkOutput("latency", 32'(cycle - e.acc), 32'(e.lat));
        end
        hold_hit = resp_hit;
        hold_row = resp_row;
        hold_col = resp_col;
      end else if (resp_valid && prev_valid) begin
        checkOutput("hold_hit", 32'(resp_hit), 32'(hold_hit));
        checkOutput("hold_row", 32'(resp_row), 32'(hold_row));
        checkOutput("hold_col", 32'(resp_col), 32'(hold_col));
      end
      prev_hs    = resp_valid && resp_ready;
      prev_valid = resp_valid;
    end
  end

  task automatic applyStimulus(input logic [10:0] x, input logic [10:0] y, input logic ehit,
                               input logic [1:0] erow, input logic [1:0] ecol, input int elat);
    int i;
    @(negedge clk);
    req_x     = x;
    req_y     = y;
    req_valid = 1'b1;
    i = 0;
    while (!req_ready && i < 50) begin
      @(negedge clk);
      i++;
    end
    if (!req_ready) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL accept_timeout: got req_ready=0 expected 1 within 50 cycles");
      req_valid = 1'b0;
      return;
    end
    sb.push_back('{hit: ehit, row: erow, col: ecol, lat: elat, acc: cycle + 1});
    n_vec++;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    checkOutput("req_ready_busy", 32'(req_ready), 32'd0);
  endtask

  task automatic drain();
    int i;
    i = 0;
    while (sb.size() != 0 && i < 60) begin
      @(negedge clk);
      i++;
    end
    if (sb.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL resp_timeout: got %0d pending expected 0", sb.size());
      sb.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_req_ready"}, 32'(req_ready), 32'd1);
    checkOutput({tag, "_resp_valid"}, 32'(resp_valid), 32'd0);
    checkOutput({tag, "_resp_hit"}, 32'(resp_hit), 32'd0);
    checkOutput({tag, "_resp_row"}, 32'(resp_row), 32'd0);
    checkOutput({tag, "_resp_col"}, 32'(resp_col), 32'd0);
  endtask

  initial begin
    int i;
    repeat (3) @(negedge clk);
    checkResetValues("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // x rows: [70,90) [A0,C0) [D0,F0); y cols: [80,C0) [E0,120) [140,180) [1A0,1E0)
    applyStimulus(11'h075, 11'h085, 1'b1, 2'd0, 2'd0, 2); drain();
    applyStimulus(11'h0D5, 11'h1A5, 1'b1, 2'd2, 2'd3, 7); drain();
    applyStimulus(11'h010, 11'h085, 1'b0, 2'd0, 2'd0, 3); drain();
    applyStimulus(11'h08F, 11'h080, 1'b1, 2'd0, 2'd0, 2); drain();
    applyStimulus(11'h090, 11'h080, 1'b0, 2'd0, 2'd0, 3); drain();
    applyStimulus(11'h0A8, 11'h07F, 1'b0, 2'd0, 2'd0, 6); drain();
    applyStimulus(11'h0A0, 11'h0E0, 1'b1, 2'd1, 2'd1, 4); drain();
    applyStimulus(11'h0BF, 11'h11F, 1'b1, 2'd1, 2'd1, 4); drain();
    applyStimulus(11'h0C0, 11'h0E0, 1'b0, 2'd0, 2'd0, 3); drain();
    applyStimulus(11'h0EF, 11'h13F, 1'b0, 2'd0, 2'd0, 7); drain();
    applyStimulus(11'h0EF, 11'h140, 1'b1, 2'd2, 2'd2, 6); drain();
    applyStimulus(11'h0D0, 11'h1DF, 1'b1, 2'd2, 2'd3, 7); drain();

    // Back-to-back without idle gaps between request and drain.
    applyStimulus(11'h075, 11'h0BF, 1'b1, 2'd0, 2'd0, 2);
    applyStimulus(11'h0AF, 11'h17F, 1'b1, 2'd1, 2'd2, 5);
    drain();

    // Backpressure: response held, stray requests ignored.
    resp_ready = 1'b0;
    applyStimulus(11'h075, 11'h085, 1'b1, 2'd0, 2'd0, 2);
    i = 0;
    while (!resp_valid && i < 20) begin
      @(negedge clk);
      i++;
    end
    checkOutput("bp_resp_valid", 32'(resp_valid), 32'd1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      req_x     = 11'h0D5;
      req_y     = 11'h1A5;
      req_valid = (k % 2) == 0;
      checkOutput("bp_req_ready", 32'(req_ready), 32'd0);
    end
    @(negedge clk);
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    drain();
    repeat (12) @(negedge clk);

    // Asynchronous reset in the middle of a row scan drops the request.
    req_x     = 11'h0D5;
    req_y     = 11'h1A5;
    req_valid = 1'b1;
    i = 0;
    while (!req_ready && i < 20) begin
      @(negedge clk);
      i++;
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 checkResetValues("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(11'h0D5, 11'h1A5, 1'b1, 2'd2, 2'd3, 7); drain();

`ifdef MINE_LOCATOR_MASK_EN
    alive_mask = 12'hFFE;
    applyStimulus(11'h075, 11'h085, 1'b0, 2'd0, 2'd0, 2); drain();
    alive_mask = 12'hFFF;
    applyStimulus(11'h075, 11'h085, 1'b1, 2'd0, 2'd0, 2);
    alive_mask = 12'hFFE;
    drain();
    alive_mask = 12'h7FF;
    applyStimulus(11'h0D5, 11'h1A5, 1'b0, 2'd2, 2'd3, 7); drain();
    alive_mask = 12'hFFF;
`endif

    repeat (10) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
